filter_result_writer: RTL

- Downstream stage of the image-filtering controller and datapath.
- Accepts the filtered pixel stream, one pixel per `in_wr` strobe, and packs PACK pixels into one output-memory word.
- Buffers packed words in a small FIFO and writes them to output memory at consecutive addresses using a wr/ack handshake.
- On the end-of-image pulse it flushes a partial word with lane strobes, then reports completion.

---
 rtl/filter_result_writer_if.sv | 30 +++
 rtl/filter_result_writer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/filter_result_writer_if.sv
// Pixel-in / memory-write bundle of the filter result writer.
// The slave modport is the writer itself; master is the controller plus output memory.
interface filter_result_writer_if #(
    parameter int PIX_W  = 8,
    parameter int PACK   = 4,
    parameter int ADDR_W = 8
);
    logic                    in_wr;
    logic [PIX_W-1:0]        in_pix;
    logic                    in_last;
    logic                    in_ready;
    logic                    mem_wr_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [PIX_W*PACK-1:0]   mem_wdata;
    logic [PACK-1:0]         mem_wstrb;
    logic                    mem_ack;
    logic                    busy;
    logic                    flush_done;
    logic                    overflow;

    modport master (
        output in_wr, in_pix, in_last, mem_ack,
        input  in_ready, mem_wr_en, mem_addr, mem_wdata, mem_wstrb, busy, flush_done, overflow
    );

    modport slave (
        input  in_wr, in_pix, in_last, mem_ack,
        output in_ready, mem_wr_en, mem_addr, mem_wdata, mem_wstrb, busy, flush_done, overflow
    );
endinterface

// File: rtl/filter_result_writer.sv
// Packs filtered pixels PACK-per-word, queues the words in a small FIFO and writes
// them to consecutive output-memory addresses; flushes a partial word at end of image.
module filter_result_writer #(
    parameter int              PIX_W      = 8,
    parameter int              PACK       = 4,
    parameter int              FIFO_DEPTH = 4,
    parameter int              ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    filter_result_writer_if.slave  bus
);
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WORD_W = PIX_W * PACK;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_FLUSH_PUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN      = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    logic [1:0]                   state;
    logic [LANE_W-1:0]            lane;
    logic [PACK-1:0][PIX_W-1:0]   pack_reg;
    logic [WORD_W-1:0]            fifo_data [FIFO_DEPTH];
    logic [PACK-1:0]              fifo_strb [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W:0]               count;
    logic [ADDR_W-1:0]            addr_q;
    logic                         overflow_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              ready;
    logic              accept;
    logic              word_done;
    logic              flush_push;
    logic              push;
    logic              pop;
    logic              lane_zero_after;
    logic [WORD_W-1:0] push_word;
    logic [PACK-1:0]   push_strb;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    // A full FIFO refuses pixels even when a pop happens on the same edge.
    assign ready      = (state == ST_RUN) && !fifo_full;
    assign accept     = bus.in_wr && ready;
    assign word_done  = accept && (lane == LAST_LANE);
    assign flush_push = (state == ST_FLUSH_PUSH) && !fifo_full;
    assign push       = word_done || flush_push;
    assign pop        = !fifo_empty && bus.mem_ack;
    assign lane_zero_after = word_done || (!accept && (lane == '0));

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        push_word = '0;
        push_strb = '0;
        for (int i = 0; i < PACK; i++) begin
            if (word_done) begin
                push_strb[i] = 1'b1;
                push_word[i*PIX_W +: PIX_W] = (LANE_W'(i) == lane) ? bus.in_pix : pack_reg[i];
            end else if (i < int'(lane)) begin
                push_strb[i] = 1'b1;
                push_word[i*PIX_W +: PIX_W] = pack_reg[i];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            lane       <= '0;
            pack_reg   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            addr_q     <= BASE_ADDR;
            overflow_q <= 1'b0;
        end else begin
            if (accept)
                pack_reg[lane] <= bus.in_pix;

            if (word_done || flush_push)
                lane <= '0;
            else if (accept)
                lane <= lane + LANE_W'(1);

            if (bus.in_wr && !ready)
                overflow_q <= 1'b1;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase

            if (state == ST_DONE)
                addr_q <= BASE_ADDR;
            else if (pop)
                addr_q <= addr_q + ADDR_W'(1);

            case (state)
                ST_RUN:        if (bus.in_last) state <= lane_zero_after ? ST_DRAIN : ST_FLUSH_PUSH;
                ST_FLUSH_PUSH: if (!fifo_full) state <= ST_DRAIN;
                ST_DRAIN:      if (fifo_empty) state <= ST_DONE;
                ST_DONE:       state <= ST_RUN;
                default:       state <= ST_RUN;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the outputs below are forced to zero while it is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_word;
            fifo_strb[wr_ptr] <= push_strb;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.mem_wr_en  = !fifo_empty;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = fifo_empty ? '0 : fifo_data[rd_ptr];
    assign bus.mem_wstrb  = fifo_empty ? '0 : fifo_strb[rd_ptr];
    assign bus.busy       = (state != ST_RUN) || !fifo_empty;
    assign bus.flush_done = (state == ST_DONE);
    assign bus.overflow   = overflow_q;
endmodule
